// File: rtl/mux_scan_nto1_if.sv
// mux_scan_nto1_if
//   Bundles the channel inputs, the scan/manual controls and the registered
//   display outputs of mux_scan_nto1.
//   master : side that drives channel data and controls (value registers)
//   slave  : the scanner itself
//   Signals: in_bus, blank_mask, scan_en, manual, manual_sel  (master -> slave)
//            out_data, sel_out, an_n, slot_tick              (slave -> master)
interface mux_scan_nto1_if #(
  parameter int N_CH = 8,
  parameter int W    = 4
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*W-1:0] in_bus;
  logic [N_CH-1:0]   blank_mask;
  logic              scan_en;
  logic              manual;
  logic [SEL_W-1:0]  manual_sel;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  sel_out;
  logic [N_CH-1:0]   an_n;
  logic              slot_tick;

  modport master (
    output in_bus, blank_mask, scan_en, manual, manual_sel,
    input  out_data, sel_out, an_n, slot_tick
  );

  modport slave (
    input  in_bus, blank_mask, scan_en, manual, manual_sel,
    output out_data, sel_out, an_n, slot_tick
  );
endinterface

// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1
//   Time-multiplexed N-to-1 selector for a 7-segment digit scan. A prescaler
//   counts PRESCALE cycles per slot; at the end of each slot the channel index
//   advances (wrapping at N_CH-1). The selected channel value, its index and an
//   active-low one-hot digit enable are registered and move together.
//   Ports:
//     clk      system clock
//     reset_n  asynchronous reset, active low
//     bus      mux_scan_nto1_if.slave (channels, blanking, scan_en, manual
//              select in; out_data, sel_out, an_n, slot_tick out)
//   Optional build macro:
//     MUXSCAN_DEADTIME_EN  force an_n to all ones for the first DEAD_CYC
//                          cycles of every scan slot (anti-ghosting).
module mux_scan_nto1 #(
  parameter int N_CH     = 8,
  parameter int W        = 4,
  parameter int PRESCALE = 100000,
  parameter int DEAD_CYC = 16
) (
  input logic           clk,
  input logic           reset_n,
  mux_scan_nto1_if.slave bus
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(PRESCALE);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_CH - 1);

  // Elaboration-time parameter sanity checks.
  if (N_CH < 2 || PRESCALE < 2 || DEAD_CYC < 0) begin : g_bad_cfg
    $error("mux_scan_nto1: illegal N_CH/PRESCALE/DEAD_CYC");
  end
`ifdef MUXSCAN_DEADTIME_EN
  if (DEAD_CYC >= PRESCALE) begin : g_bad_dead
    $error("mux_scan_nto1: DEAD_CYC must be below PRESCALE");
  end
  localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYC);
`endif

  logic [CNT_W-1:0] cnt_r;
  logic [SEL_W-1:0] idx_r;
  logic [CNT_W-1:0] ncnt_s;
  logic [SEL_W-1:0] nidx_s;
  logic             tick_s;
  logic [N_CH-1:0]  hot_s;
  logic [W-1:0]     data_s;
  logic             show_s;
  logic             dead_s;

  logic [W-1:0]     out_data_r;
  logic [SEL_W-1:0] sel_out_r;
  logic [N_CH-1:0]  an_n_r;
  logic             slot_tick_r;

  // Next prescaler/index state; manual overrides scan and swallows any tick.
  always_comb begin
    tick_s = 1'b0;
    ncnt_s = cnt_r;
    nidx_s = idx_r;
    if (bus.manual) begin
      ncnt_s = '0;
      nidx_s = bus.manual_sel;
    end else if (bus.scan_en) begin
      if (cnt_r == CNT_LAST) begin
        tick_s = 1'b1;
        ncnt_s = '0;
        // >= also pulls an out-of-range index left over from manual mode back to 0
        nidx_s = (idx_r >= IDX_LAST) ? '0 : idx_r + SEL_W'(1);
      end else begin
        ncnt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      ncnt_s = cnt_r;
      nidx_s = idx_r;
    end
  end

  // Decode the next index into a one-hot and AND-OR mux the channel value.
  // An index >= N_CH matches no channel, so it yields zero data and no enable.
  always_comb begin
    hot_s  = '0;
    data_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      hot_s[k] = (nidx_s == SEL_W'(k));
      data_s   = data_s | (bus.in_bus[k*W +: W] & {W{hot_s[k]}});
    end
    show_s = |(hot_s & ~bus.blank_mask);
  end

  // Dead-time window at the start of each scan slot (manual mode exempt).
  always_comb begin
`ifdef MUXSCAN_DEADTIME_EN
    dead_s = ~bus.manual & (ncnt_s < DEAD_LIM);
`else
    dead_s = 1'b0;
`endif
  end

  // Prescaler and channel index state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else begin
      cnt_r <= ncnt_s;
      idx_r <= nidx_s;
    end
  end

  // Output register, loaded from the next index so all outputs move together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_r  <= '0;
      sel_out_r   <= '0;
      an_n_r      <= '1;
      slot_tick_r <= 1'b0;
    end else begin
      out_data_r  <= show_s ? data_s : '0;
      sel_out_r   <= nidx_s;
      an_n_r      <= (show_s && !dead_s) ? ~hot_s : '1;
      slot_tick_r <= tick_s;
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.sel_out   = sel_out_r;
  assign bus.an_n      = an_n_r;
  assign bus.slot_tick = slot_tick_r;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// tb_mux_scan_nto1
//   Two scanners share clock, reset and stimulus: A (8 channels, 4-cycle
//   slots) and B (6 channels, 8-cycle slots, dead time of 2 when the
//   MUXSCAN_DEADTIME_EN macro is defined). Outputs are compared on the falling
//   edge against an integer-arithmetic reference model.
module tb_mux_scan_nto1;
  localparam int NA = 8;
  localparam int PA = 4;
  localparam int NB = 6;
  localparam int PB = 8;
`ifdef MUXSCAN_DEADTIME_EN
  localparam int DEAD_A = 1;
  localparam int DEAD_B = 2;
`else
  localparam int DEAD_A = 0;
  localparam int DEAD_B = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic [31:0] in_bus;
  logic [7:0]  blank;
  logic        scan_en;
  logic        manual;
  logic [2:0]  msel_a;
  logic [2:0]  msel_b;
  int          checks = 0;
  int          errors = 0;

  mux_scan_nto1_if #(.N_CH(NA), .W(4)) ifa ();
  mux_scan_nto1_if #(.N_CH(NB), .W(4)) ifb ();

  assign ifa.in_bus     = in_bus;
  assign ifa.blank_mask = blank;
  assign ifa.scan_en    = scan_en;
  assign ifa.manual     = manual;
  assign ifa.manual_sel = msel_a;
  assign ifb.in_bus     = in_bus[23:0];
  assign ifb.blank_mask = blank[5:0];
  assign ifb.scan_en    = scan_en;
  assign ifb.manual     = manual;
  assign ifb.manual_sel = msel_b;

  mux_scan_nto1 #(.N_CH(NA), .W(4), .PRESCALE(PA), .DEAD_CYC(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa));
  mux_scan_nto1 #(.N_CH(NB), .W(4), .PRESCALE(PB), .DEAD_CYC(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         ma_cnt, ma_idx, mb_cnt, mb_idx;
  logic [3:0] ea_data, eb_data;
  logic [7:0] ea_an;
  logic [5:0] eb_an;
  logic       ea_tick, eb_tick;

  function automatic int f_ncnt(int p, int cnt);
    if (manual) return 0;
    if (!scan_en) return cnt;
    return (cnt + 1) % p;
  endfunction

  function automatic int f_nidx(int p, int nch, int cnt, int idx, int msel);
    if (manual) return msel;
    if (!scan_en || cnt != p - 1) return idx;
    return (idx >= nch - 1) ? 0 : idx + 1;
  endfunction

  function automatic logic f_tick(int p, int cnt);
    return !manual && scan_en && (cnt == p - 1);
  endfunction

  function automatic logic [3:0] f_data(int nch, int nidx);
    if (nidx >= nch || blank[nidx]) return 4'h0;
    return in_bus[nidx*4 +: 4];
  endfunction

  function automatic logic [7:0] f_an(int nch, int nidx, int ncnt, int dead);
    logic [7:0] all;
    all = 8'((1 << nch) - 1);
    if (nidx >= nch || blank[nidx] || (!manual && ncnt < dead)) return all;
    return all & ~(8'd1 << nidx);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma_cnt <= 0; ma_idx <= 0; ea_data <= 4'h0; ea_an <= 8'hFF; ea_tick <= 1'b0;
      mb_cnt <= 0; mb_idx <= 0; eb_data <= 4'h0; eb_an <= 6'h3F; eb_tick <= 1'b0;
    end else begin
      ma_cnt  <= f_ncnt(PA, ma_cnt);
      ma_idx  <= f_nidx(PA, NA, ma_cnt, ma_idx, int'(msel_a));
      ea_data <= f_data(NA, f_nidx(PA, NA, ma_cnt, ma_idx, int'(msel_a)));
      ea_an   <= f_an(NA, f_nidx(PA, NA, ma_cnt, ma_idx, int'(msel_a)), f_ncnt(PA, ma_cnt), DEAD_A);
      ea_tick <= f_tick(PA, ma_cnt);
      mb_cnt  <= f_ncnt(PB, mb_cnt);
      mb_idx  <= f_nidx(PB, NB, mb_cnt, mb_idx, int'(msel_b));
      eb_data <= f_data(NB, f_nidx(PB, NB, mb_cnt, mb_idx, int'(msel_b)));
      eb_an   <= 6'(f_an(NB, f_nidx(PB, NB, mb_cnt, mb_idx, int'(msel_b)), f_ncnt(PB, mb_cnt), DEAD_B));
      eb_tick <= f_tick(PB, mb_cnt);
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_n = 1'b0; in_bus = 32'h76543210; blank = 8'h00;
    scan_en = 1'b1; manual = 1'b0; msel_a = 3'd0; msel_b = 3'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick} !== {4'h0, 3'd0, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_a: got data=%h sel=%0d an=%h tick=%b, want 0/0/ff/0",
               ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick);
    end
    checks++;
    if ({ifb.out_data, ifb.sel_out, ifb.an_n, ifb.slot_tick} !== {4'h0, 3'd0, 6'h3F, 1'b0}) begin
      errors++;
      $display("FAIL reset_b: got data=%h sel=%0d an=%h tick=%b, want 0/0/3f/0",
               ifb.out_data, ifb.sel_out, ifb.an_n, ifb.slot_tick);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_scan;
    int ticks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if ({ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick} !== {ea_data, 3'(ma_idx), ea_an, ea_tick}) begin
        errors++;
        $display("FAIL scan_a @%0t: got %h/%0d/%h/%b want %h/%0d/%h/%b", $time, ifa.out_data,
                 ifa.sel_out, ifa.an_n, ifa.slot_tick, ea_data, ma_idx, ea_an, ea_tick);
      end
      if (ifa.slot_tick) ticks++;
    end
    checks++;
    if (ticks != 10) begin
      errors++;
      $display("FAIL scan_ticks: got %0d ticks in 40 cycles, want 10", ticks);
    end
    blank = 8'h04;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if ({ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick} !== {ea_data, 3'(ma_idx), ea_an, ea_tick}) begin
        errors++;
        $display("FAIL blank_a @%0t: got %h/%0d/%h/%b want %h/%0d/%h/%b", $time, ifa.out_data,
                 ifa.sel_out, ifa.an_n, ifa.slot_tick, ea_data, ma_idx, ea_an, ea_tick);
      end
      if (ifa.sel_out == 3'd2) begin
        checks++;
        if ({ifa.out_data, ifa.an_n} !== {4'h0, 8'hFF}) begin
          errors++;
          $display("FAIL blank_ch2: got data=%h an=%h want 0/ff", ifa.out_data, ifa.an_n);
        end
      end
    end
    blank = 8'h00;
  endtask

  task automatic test_manual;
    @(negedge clk);
    manual = 1'b1; msel_a = 3'd5; msel_b = 3'd7;
    @(negedge clk);
    checks++;
    if ({ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick} !== {4'h5, 3'd5, 8'hDF, 1'b0}) begin
      errors++;
      $display("FAIL manual_a: got %h/%0d/%h/%b want 5/5/df/0",
               ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick);
    end
    checks++;
    if ({ifb.out_data, ifb.sel_out, ifb.an_n, ifb.slot_tick} !== {4'h0, 3'd7, 6'h3F, 1'b0}) begin
      errors++;
      $display("FAIL manual_b_oor: got %h/%0d/%h/%b want 0/7/3f/0",
               ifb.out_data, ifb.sel_out, ifb.an_n, ifb.slot_tick);
    end
    msel_b = 3'd2;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 3) manual = 1'b0;
      checks++;
      if ({ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick} !== {ea_data, 3'(ma_idx), ea_an, ea_tick} ||
          {ifb.out_data, ifb.sel_out, ifb.an_n, ifb.slot_tick} !== {eb_data, 3'(mb_idx), eb_an, eb_tick}) begin
        errors++;
        $display("FAIL manual_resume @%0t: a=%h/%0d/%h/%b want %h/%0d/%h/%b b=%h/%0d/%h/%b want %h/%0d/%h/%b",
                 $time, ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick, ea_data, ma_idx, ea_an, ea_tick,
                 ifb.out_data, ifb.sel_out, ifb.an_n, ifb.slot_tick, eb_data, mb_idx, eb_an, eb_tick);
      end
    end
  endtask

  task automatic test_freeze;
    int budget = 0;
    while (ifa.sel_out != 3'd3 && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (ifa.sel_out != 3'd3) begin
      errors++;
      $display("FAIL freeze_wait: sel_out=%0d never reached 3", ifa.sel_out);
    end
    scan_en = 1'b0;
    in_bus[15:12] = 4'hA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({ifa.out_data, ifa.sel_out, ifa.slot_tick} !== {4'hA, 3'd3, 1'b0} ||
          {ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick} !== {ea_data, 3'(ma_idx), ea_an, ea_tick}) begin
        errors++;
        $display("FAIL freeze_hold @%0t: got %h/%0d/%h/%b want a/3/%h/0",
                 $time, ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick, ea_an);
      end
    end
    scan_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick} !== {ea_data, 3'(ma_idx), ea_an, ea_tick}) begin
        errors++;
        $display("FAIL freeze_resume @%0t: got %h/%0d/%h/%b want %h/%0d/%h/%b", $time, ifa.out_data,
                 ifa.sel_out, ifa.an_n, ifa.slot_tick, ea_data, ma_idx, ea_an, ea_tick);
      end
    end
    in_bus = 32'h76543210;
  endtask

  task automatic test_async_reset;
    int budget = 0;
    int zeros = 0;
    while (ifa.sel_out != 3'd6 && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (ifa.sel_out != 3'd6) begin
      errors++;
      $display("FAIL areset_wait: sel_out=%0d never reached 6", ifa.sel_out);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick} !== {4'h0, 3'd0, 8'hFF, 1'b0} ||
        {ifb.out_data, ifb.sel_out, ifb.an_n} !== {4'h0, 3'd0, 6'h3F}) begin
      errors++;
      $display("FAIL areset_async: a=%h/%0d/%h/%b b=%h/%0d/%h want 0/0/ff/0 and 0/0/3f",
               ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick, ifb.out_data, ifb.sel_out, ifb.an_n);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick} !== {ea_data, 3'(ma_idx), ea_an, ea_tick}) begin
        errors++;
        $display("FAIL areset_restart @%0t: got %h/%0d/%h/%b want %h/%0d/%h/%b", $time, ifa.out_data,
                 ifa.sel_out, ifa.an_n, ifa.slot_tick, ea_data, ma_idx, ea_an, ea_tick);
      end
      if (ifa.sel_out == 3'd0) zeros++;
      @(negedge clk);
    end
    checks++;
    if (zeros != 4) begin
      errors++;
      $display("FAIL areset_slot0: index 0 lasted %0d cycles, want 4", zeros);
    end
  endtask

  task automatic test_deadtime;
    int off = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ({ifb.out_data, ifb.sel_out, ifb.an_n, ifb.slot_tick} !== {eb_data, 3'(mb_idx), eb_an, eb_tick}) begin
        errors++;
        $display("FAIL dead_b @%0t: got %h/%0d/%h/%b want %h/%0d/%h/%b", $time, ifb.out_data,
                 ifb.sel_out, ifb.an_n, ifb.slot_tick, eb_data, mb_idx, eb_an, eb_tick);
      end
      if (ifb.an_n == 6'h3F) off++;
    end
    checks++;
    if (off != 2 * DEAD_B) begin
      errors++;
      $display("FAIL dead_count: an_n dark for %0d of 16 cycles, want %0d", off, 2 * DEAD_B);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if ({ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick} !== {ea_data, 3'(ma_idx), ea_an, ea_tick} ||
          {ifb.out_data, ifb.sel_out, ifb.an_n, ifb.slot_tick} !== {eb_data, 3'(mb_idx), eb_an, eb_tick}) begin
        errors++;
        $display("FAIL random @%0t: a=%h/%0d/%h/%b want %h/%0d/%h/%b b=%h/%0d/%h/%b want %h/%0d/%h/%b",
                 $time, ifa.out_data, ifa.sel_out, ifa.an_n, ifa.slot_tick, ea_data, ma_idx, ea_an, ea_tick,
                 ifb.out_data, ifb.sel_out, ifb.an_n, ifb.slot_tick, eb_data, mb_idx, eb_an, eb_tick);
      end
      in_bus  = $urandom;
      blank   = 8'($urandom) & 8'($urandom);
      scan_en = ($urandom_range(0, 9) != 0);
      manual  = ($urandom_range(0, 19) == 0);
      msel_a  = 3'($urandom);
      msel_b  = 3'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_manual();
    test_freeze();
    test_async_reset();
    test_deadtime();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
